// File: rtl/elastic_pipe_register.sv
// Elastic DEPTH-stage register pipeline with valid/ready handshake on both ends.
// Empty stages always accept, so bubbles collapse under back-pressure.
module elastic_pipe_register #(
  parameter int unsigned     WORD_LENGTH = 4,
  parameter int unsigned     WORD        = WORD_LENGTH * 2,
  parameter int unsigned     DEPTH       = 3,
  parameter logic [WORD-1:0] CLEAR_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         sync_clear,
  input  logic                         in_valid,
  input  logic [WORD-1:0]              in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WORD-1:0]              out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]           valid_q, valid_d;
  logic [DEPTH-1:0]           adv;
  logic [DEPTH-1:0][WORD-1:0] data_q, data_d;
  logic [OccW-1:0]            occ_q, occ_d;
  logic                       gate;
  logic                       in_fire, out_fire;

  assign gate      = enable & ~sync_clear;
  assign out_valid = valid_q[DEPTH-1] & gate;
  assign out_data  = data_q[DEPTH-1];
  // Held low during reset so nothing upstream sees a handshake while state is cleared.
  assign in_ready  = adv[0] & gate & reset;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = occ_q;

  // A stage advances if any stage from it to the output is empty, or the output pops.
  always_comb begin
    adv = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      adv[i] = out_ready;
      for (int j = i; j < int'(DEPTH); j++) begin
        adv[i] = adv[i] | ~valid_q[j];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    occ_d   = occ_q;
    if (sync_clear) begin
      valid_d = '0;
      data_d  = {DEPTH{CLEAR_VALUE}};
      occ_d   = '0;
    end else begin
      if (adv[0]) begin
        valid_d[0] = in_valid;
        if (in_valid) begin
          data_d[0] = in_data;
        end
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (adv[i]) begin
          valid_d[i] = valid_q[i-1];
          if (valid_q[i-1]) begin
            data_d[i] = data_q[i-1];
          end
        end
      end
      occ_d = occ_q + OccW'(in_fire) - OccW'(out_fire);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      data_q  <= {DEPTH{CLEAR_VALUE}};
      occ_q   <= '0;
    end else if (enable) begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

endmodule

// File: tb/tb_elastic_pipe_register.sv
// Bench for elastic_pipe_register: DEPTH=3 and DEPTH=1 instances on shared stimulus,
// per-cycle expected outputs plus an in-order scoreboard for each instance.
module tb_elastic_pipe_register;

  localparam int unsigned W = 8;

  logic         clk, reset, enable, sync_clear, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         ir3, ov3, ir1, ov1;
  logic [W-1:0] od3, od1;
  logic [1:0]   occ3;
  logic [0:0]   occ1;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] q3[$];
  logic [W-1:0] q1[$];
  int           om3 = 0;
  int           om1 = 0;

  elastic_pipe_register #(.WORD_LENGTH(4), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .enable(enable), .sync_clear(sync_clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir3),
    .out_valid(ov3), .out_data(od3), .out_ready(out_ready), .occupancy(occ3)
  );

  elastic_pipe_register #(.WORD_LENGTH(4), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset), .enable(enable), .sync_clear(sync_clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_ready(out_ready), .occupancy(occ1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic sb_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got pop from empty queue want none", name);
  endtask

  // Called at the sampling point; handshakes seen here complete at the next edge.
  task automatic sb_tick();
    logic [W-1:0] e;
    if (reset) begin
      chk("occ3_model", occ3, om3);
      chk("occ1_model", occ1, om1);
      if (ov3 && out_ready) begin
        if (q3.size() == 0) sb_fail("sb3_order");
        else begin
          e = q3.pop_front();
          chk("sb3_order", od3, e);
        end
        om3--;
      end
      if (in_valid && ir3) begin
        q3.push_back(in_data);
        om3++;
      end
      if (ov1 && out_ready) begin
        if (q1.size() == 0) sb_fail("sb1_order");
        else begin
          e = q1.pop_front();
          chk("sb1_order", od1, e);
        end
        om1--;
      end
      if (in_valid && ir1) begin
        q1.push_back(in_data);
        om1++;
      end
    end
    if (!reset || (enable && sync_clear)) begin
      q3.delete();
      q1.delete();
      om3 = 0;
      om1 = 0;
    end
  endtask

  // sel: 0 checks the DEPTH=3 instance, 1 the DEPTH=1 instance, 2 checks neither.
  task automatic cyc(input string tag, input logic en, input logic clr, input logic iv,
                     input logic [W-1:0] id, input logic ordy, input int sel,
                     input logic e_ir, input logic e_ov, input logic [W-1:0] e_od,
                     input bit chk_od, input int e_occ);
    enable     = en;
    sync_clear = clr;
    in_valid   = iv;
    in_data    = id;
    out_ready  = ordy;
    @(negedge clk);
    if (sel == 0) begin
      chk({tag, ".in_ready"}, ir3, e_ir);
      chk({tag, ".out_valid"}, ov3, e_ov);
      chk({tag, ".occupancy"}, occ3, e_occ);
      if (e_ov || chk_od) chk({tag, ".out_data"}, od3, e_od);
    end else if (sel == 1) begin
      chk({tag, ".in_ready"}, ir1, e_ir);
      chk({tag, ".out_valid"}, ov1, e_ov);
      chk({tag, ".occupancy"}, occ1, e_occ);
      if (e_ov || chk_od) chk({tag, ".out_data"}, od1, e_od);
    end
    sb_tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         e_ir;
    logic         e_ov;
    logic [W-1:0] e_od;
    int           e_occ;
  } vec_t;

  vec_t stream3[10];

  initial begin
    stream3[0] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 8'h00, 0};
    stream3[1] = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 8'h00, 1};
    stream3[2] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 8'h00, 2};
    stream3[3] = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h01, 3};
    stream3[4] = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h02, 3};
    stream3[5] = '{1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 8'h03, 3};
    stream3[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 3};
    stream3[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 2};
    stream3[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h06, 1};
    stream3[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};

    reset = 1'b0;
    enable = 1'b1;
    sync_clear = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    #1;

    // Reset with a word offered
    cyc("rst",      1, 0, 1, 8'hAA, 1, 0, 0, 0, 8'h00, 1, 0);
    cyc("rst1",     1, 0, 1, 8'hAA, 1, 1, 0, 0, 8'h00, 1, 0);
    reset = 1'b1;
    cyc("rst_rel",  1, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 1, 0);

    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("stream3[%0d]", i), 1, 0, stream3[i].iv, stream3[i].id, stream3[i].ordy,
          0, stream3[i].e_ir, stream3[i].e_ov, stream3[i].e_od, 1'b0, stream3[i].e_occ);
    end

    // Async reset mid-transfer clears without waiting for an edge
    cyc("ar_p0",    1, 0, 1, 8'hC1, 0, 0, 1, 0, 8'h00, 0, 0);
    cyc("ar_p1",    1, 0, 1, 8'hC2, 0, 0, 1, 0, 8'h00, 0, 1);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("ar_now.occupancy", occ3, 0);
    chk("ar_now.in_ready", ir3, 0);
    chk("ar_now.out_data", od3, 8'h00);
    cyc("ar_hold",  1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0);
    reset = 1'b1;
    cyc("ar_rel",   1, 0, 1, 8'hD1, 0, 0, 1, 0, 8'h00, 0, 0);
    cyc("ar_drain", 1, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 1);
    cyc("ar_d1",    1, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 1);
    cyc("ar_d2",    1, 0, 0, 8'h00, 1, 0, 1, 1, 8'hD1, 0, 1);
    cyc("ar_d3",    1, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0);

    // Back-pressure, DEPTH=3
    cyc("bp_11",    1, 0, 1, 8'h11, 0, 0, 1, 0, 8'h00, 0, 0);
    cyc("bp_22",    1, 0, 1, 8'h22, 0, 0, 1, 0, 8'h00, 0, 1);
    cyc("bp_33",    1, 0, 1, 8'h33, 0, 0, 1, 0, 8'h00, 0, 2);
    cyc("bp_44a",   1, 0, 1, 8'h44, 0, 0, 0, 1, 8'h11, 0, 3);
    cyc("bp_44b",   1, 0, 1, 8'h44, 0, 0, 0, 1, 8'h11, 0, 3);
    cyc("bp_rel",   1, 0, 1, 8'h44, 1, 0, 1, 1, 8'h11, 0, 3);
    cyc("bp_o22",   1, 0, 0, 8'h00, 1, 0, 1, 1, 8'h22, 0, 3);
    cyc("bp_o33",   1, 0, 0, 8'h00, 1, 0, 1, 1, 8'h33, 0, 2);
    cyc("bp_o44",   1, 0, 0, 8'h00, 1, 0, 1, 1, 8'h44, 0, 1);
    cyc("bp_end",   1, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0);

    // Bubble collapse
    cyc("bc_55",    1, 0, 1, 8'h55, 0, 0, 1, 0, 8'h00, 0, 0);
    cyc("bc_i0",    1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1);
    cyc("bc_i1",    1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1);
    cyc("bc_66",    1, 0, 1, 8'h66, 0, 0, 1, 1, 8'h55, 0, 1);
    cyc("bc_i2",    1, 0, 0, 8'h00, 0, 0, 1, 1, 8'h55, 0, 2);
    cyc("bc_i3",    1, 0, 0, 8'h00, 0, 0, 1, 1, 8'h55, 0, 2);
    cyc("bc_o55",   1, 0, 0, 8'h00, 1, 0, 1, 1, 8'h55, 0, 2);
    cyc("bc_o66",   1, 0, 0, 8'h00, 1, 0, 1, 1, 8'h66, 0, 1);
    cyc("bc_end",   1, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0);

    // Flush with a word offered in the flush cycle
    cyc("fl_a1",    1, 0, 1, 8'hA1, 0, 0, 1, 0, 8'h00, 0, 0);
    cyc("fl_a2",    1, 0, 1, 8'hA2, 0, 0, 1, 0, 8'h00, 0, 1);
    cyc("fl_a3",    1, 0, 1, 8'hA3, 0, 0, 1, 0, 8'h00, 0, 2);
    cyc("fl_clr",   1, 1, 1, 8'h77, 1, 0, 0, 0, 8'h00, 0, 3);
    cyc("fl_77",    1, 0, 1, 8'h77, 0, 0, 1, 0, 8'h00, 1, 0);
    cyc("fl_m0",    1, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 1);
    cyc("fl_m1",    1, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 1);
    cyc("fl_o77",   1, 0, 0, 8'h00, 1, 0, 1, 1, 8'h77, 0, 1);
    cyc("fl_end",   1, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0);

    // Freeze mid-stream; sync_clear must be ignored while frozen
    cyc("fz_b1",    1, 0, 1, 8'hB1, 1, 0, 1, 0, 8'h00, 0, 0);
    cyc("fz_b2",    1, 0, 1, 8'hB2, 1, 0, 1, 0, 8'h00, 0, 1);
    cyc("fz_b3",    1, 0, 1, 8'hB3, 1, 0, 1, 0, 8'h00, 0, 2);
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("fz_hold%0d", i), 0, 1, 1, 8'hB4, 1, 0, 0, 0, 8'hB1, 1, 3);
    end
    cyc("fz_b4",    1, 0, 1, 8'hB4, 1, 0, 1, 1, 8'hB1, 0, 3);
    cyc("fz_b5",    1, 0, 1, 8'hB5, 1, 0, 1, 1, 8'hB2, 0, 3);
    cyc("fz_o3",    1, 0, 0, 8'h00, 1, 0, 1, 1, 8'hB3, 0, 3);
    cyc("fz_o4",    1, 0, 0, 8'h00, 1, 0, 1, 1, 8'hB4, 0, 2);
    cyc("fz_o5",    1, 0, 0, 8'h00, 1, 0, 1, 1, 8'hB5, 0, 1);
    cyc("fz_end",   1, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0);

    // DEPTH=1 instance
    cyc("d1_flush", 1, 1, 0, 8'h00, 0, 2, 0, 0, 8'h00, 0, 0);
    cyc("d1_s01",   1, 0, 1, 8'h01, 1, 1, 1, 0, 8'h00, 0, 0);
    cyc("d1_s02",   1, 0, 1, 8'h02, 1, 1, 1, 1, 8'h01, 0, 1);
    cyc("d1_s03",   1, 0, 1, 8'h03, 1, 1, 1, 1, 8'h02, 0, 1);
    cyc("d1_s04",   1, 0, 1, 8'h04, 1, 1, 1, 1, 8'h03, 0, 1);
    cyc("d1_so4",   1, 0, 0, 8'h00, 1, 1, 1, 1, 8'h04, 0, 1);
    cyc("d1_send",  1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0, 0);
    cyc("d1_b11",   1, 0, 1, 8'h11, 0, 1, 1, 0, 8'h00, 0, 0);
    cyc("d1_b22a",  1, 0, 1, 8'h22, 0, 1, 0, 1, 8'h11, 0, 1);
    cyc("d1_b22b",  1, 0, 1, 8'h22, 0, 1, 0, 1, 8'h11, 0, 1);
    cyc("d1_brel",  1, 0, 1, 8'h22, 1, 1, 1, 1, 8'h11, 0, 1);
    cyc("d1_bo22",  1, 0, 0, 8'h00, 1, 1, 1, 1, 8'h22, 0, 1);
    cyc("d1_bend",  1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0, 0);

    for (int i = 0; i < 5; i++) begin
      cyc($sformatf("drain%0d", i), 1, 0, 0, 8'h00, 1, 2, 0, 0, 8'h00, 0, 0);
    end
    chk("sb3_left", q3.size(), 0);
    chk("sb1_left", q1.size(), 0);
    chk("occ3_final", occ3, 0);
    chk("occ1_final", occ1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
